// File: rtl/gifplayer_param_onchip_ram.sv
// ============================================================================
// Module   : gifplayer_param_onchip_ram
// Brief    : Parametrised on-chip RAM with an Avalon-MM read/write port A and
//            an independent read-only port B, both with pipelined read valids.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gifplayer_param_onchip_ram #(
    parameter int    DATA_W       = 16,
    parameter int    ADDR_W       = 2,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "gifplayer_param_onchip_ram.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  freeze,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic                  b_req,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_valid
);

    localparam int c_DEPTH  = 1 << ADDR_W;
    localparam int c_NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem   [c_DEPTH];
    logic              r_a_vld [READ_LATENCY];
    logic [DATA_W-1:0] r_a_dat [READ_LATENCY];
    logic              r_b_vld [READ_LATENCY];
    logic [DATA_W-1:0] r_b_dat [READ_LATENCY];

    logic w_a_wr;
    logic w_a_rd;
    logic w_b_rd;
    logic w_unused_init;

    // Initial contents are bound to the array from INIT_FILE by the device
    // programming flow at load time; no run-time logic depends on it.
    assign w_unused_init = (INIT_FILE != "");

    assign w_a_wr = a_chipselect & a_write & clken & ~freeze;
    assign w_a_rd = a_chipselect & a_read & ~a_write & clken;
    assign w_b_rd = b_req & clken;

    // Array is never reset so that its contents survive reset_n.
    always_ff @(posedge clk) begin
        if (w_a_wr) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (a_byteenable[i]) begin
                    r_mem[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write lands, which gives
    // port B old data on a same-cycle collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_a_vld[i] <= 1'b0;
                r_a_dat[i] <= '0;
                r_b_vld[i] <= 1'b0;
                r_b_dat[i] <= '0;
            end
        end else if (clken) begin
            r_a_vld[0] <= w_a_rd;
            r_b_vld[0] <= w_b_rd;
            if (w_a_rd) begin
                r_a_dat[0] <= r_mem[a_address];
            end
            if (w_b_rd) begin
                r_b_dat[0] <= r_mem[b_address];
            end
            // Data stages only move on valid so the outputs hold their last value.
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_a_vld[i] <= r_a_vld[i-1];
                r_b_vld[i] <= r_b_vld[i-1];
                if (r_a_vld[i-1]) begin
                    r_a_dat[i] <= r_a_dat[i-1];
                end
                if (r_b_vld[i-1]) begin
                    r_b_dat[i] <= r_b_dat[i-1];
                end
            end
        end
    end

    assign a_readdata      = r_a_dat[READ_LATENCY-1];
    assign a_readdatavalid = r_a_vld[READ_LATENCY-1];
    assign b_rdata         = r_b_dat[READ_LATENCY-1];
    assign b_valid         = r_b_vld[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_gifplayer_param_onchip_ram.sv
// ============================================================================
// Module   : tb_gifplayer_param_onchip_ram
// Brief    : Bench for two RAM configurations (16x4 LAT1, 32x16 LAT2) against
//            a queue-based reference model of memory and read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gifplayer_param_onchip_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        d1_clken, d1_freeze, d1_cs, d1_rd, d1_wr, d1_b_req;
    logic [1:0]  d1_a_addr, d1_b_addr, d1_be;
    logic [15:0] d1_wd, d1_rdata, d1_b_rdata;
    logic        d1_rvalid, d1_b_valid;

    logic        d2_clken, d2_freeze, d2_cs, d2_rd, d2_wr, d2_b_req;
    logic [3:0]  d2_a_addr, d2_b_addr, d2_be;
    logic [31:0] d2_wd, d2_rdata, d2_b_rdata;
    logic        d2_rvalid, d2_b_valid;

    gifplayer_param_onchip_ram #(.DATA_W(16), .ADDR_W(2), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clken(d1_clken), .freeze(d1_freeze),
        .a_address(d1_a_addr), .a_chipselect(d1_cs), .a_read(d1_rd), .a_write(d1_wr),
        .a_byteenable(d1_be), .a_writedata(d1_wd), .a_readdata(d1_rdata),
        .a_readdatavalid(d1_rvalid), .b_address(d1_b_addr), .b_req(d1_b_req),
        .b_rdata(d1_b_rdata), .b_valid(d1_b_valid)
    );

    gifplayer_param_onchip_ram #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clken(d2_clken), .freeze(d2_freeze),
        .a_address(d2_a_addr), .a_chipselect(d2_cs), .a_read(d2_rd), .a_write(d2_wr),
        .a_byteenable(d2_be), .a_writedata(d2_wd), .a_readdata(d2_rdata),
        .a_readdatavalid(d2_rvalid), .b_address(d2_b_addr), .b_req(d2_b_req),
        .b_rdata(d2_b_rdata), .b_valid(d2_b_valid)
    );

    // Reference model: memory arrays plus queues of reads tagged with the
    // enabled-cycle number on which their data is due.
    typedef struct { int due; logic [31:0] d; } pend_t;
    logic [15:0] m1 [4];
    logic [31:0] m2 [16];
    pend_t qa1[$], qb1[$], qa2[$], qb2[$];
    int en1 = 0, en2 = 0;
    logic        e1_av, e1_bv, e2_av, e2_bv;
    logic [15:0] e1_ad, e1_bd;
    logic [31:0] e2_ad, e2_bd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        qa1.delete(); qb1.delete(); qa2.delete(); qb2.delete();
        e1_av = 0; e1_bv = 0; e2_av = 0; e2_bv = 0;
        e1_ad = '0; e1_bd = '0; e2_ad = '0; e2_bd = '0;
    endtask

    task automatic idle();
        d1_clken = 1; d1_freeze = 0; d1_cs = 0; d1_rd = 0; d1_wr = 0; d1_b_req = 0;
        d1_a_addr = 0; d1_b_addr = 0; d1_be = 0; d1_wd = 0;
        d2_clken = 1; d2_freeze = 0; d2_cs = 0; d2_rd = 0; d2_wr = 0; d2_b_req = 0;
        d2_a_addr = 0; d2_b_addr = 0; d2_be = 0; d2_wd = 0;
    endtask

    task automatic tick();
        pend_t p;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (d1_clken) begin
                en1++;
                if (d1_cs && d1_rd && !d1_wr) qa1.push_back('{en1, {16'h0, m1[d1_a_addr]}});
                if (d1_b_req) qb1.push_back('{en1, {16'h0, m1[d1_b_addr]}});
                if (d1_cs && d1_wr && !d1_freeze)
                    for (int k = 0; k < 2; k++) if (d1_be[k]) m1[d1_a_addr][k*8 +: 8] = d1_wd[k*8 +: 8];
                e1_av = 0; e1_bv = 0;
                if (qa1.size() != 0 && qa1[0].due == en1) begin p = qa1.pop_front(); e1_av = 1; e1_ad = p.d[15:0]; end
                if (qb1.size() != 0 && qb1[0].due == en1) begin p = qb1.pop_front(); e1_bv = 1; e1_bd = p.d[15:0]; end
            end
            if (d2_clken) begin
                en2++;
                if (d2_cs && d2_rd && !d2_wr) qa2.push_back('{en2 + 1, m2[d2_a_addr]});
                if (d2_b_req) qb2.push_back('{en2 + 1, m2[d2_b_addr]});
                if (d2_cs && d2_wr && !d2_freeze)
                    for (int k = 0; k < 4; k++) if (d2_be[k]) m2[d2_a_addr][k*8 +: 8] = d2_wd[k*8 +: 8];
                e2_av = 0; e2_bv = 0;
                if (qa2.size() != 0 && qa2[0].due == en2) begin p = qa2.pop_front(); e2_av = 1; e2_ad = p.d; end
                if (qb2.size() != 0 && qb2[0].due == en2) begin p = qb2.pop_front(); e2_bv = 1; e2_bd = p.d; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle();
        model_reset();
        tick(); tick();
        n_checks++; if (d1_rvalid !== 1'b0) $display("FAIL reset d1_a_valid got %b exp 0", d1_rvalid); else n_pass++;
        n_checks++; if (d1_rdata !== 16'h0) $display("FAIL reset d1_a_data got %h exp 0", d1_rdata); else n_pass++;
        n_checks++; if (d1_b_valid !== 1'b0) $display("FAIL reset d1_b_valid got %b exp 0", d1_b_valid); else n_pass++;
        n_checks++; if (d1_b_rdata !== 16'h0) $display("FAIL reset d1_b_data got %h exp 0", d1_b_rdata); else n_pass++;
        n_checks++; if (d2_rvalid !== 1'b0) $display("FAIL reset d2_a_valid got %b exp 0", d2_rvalid); else n_pass++;
        n_checks++; if (d2_rdata !== 32'h0) $display("FAIL reset d2_a_data got %h exp 0", d2_rdata); else n_pass++;
        n_checks++; if (d2_b_valid !== 1'b0) $display("FAIL reset d2_b_valid got %b exp 0", d2_b_valid); else n_pass++;
        n_checks++; if (d2_b_rdata !== 32'h0) $display("FAIL reset d2_b_data got %h exp 0", d2_b_rdata); else n_pass++;
        reset_n = 1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            idle();
            d1_cs = (i < 4); d1_wr = (i < 4); d1_a_addr = 2'(i); d1_be = 2'b11; d1_wd = 16'($urandom);
            d2_cs = 1; d2_wr = 1; d2_a_addr = 4'(i); d2_be = 4'hF; d2_wd = $urandom;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_directed();
        idle();
        d1_cs = 1; d1_wr = 1; d1_a_addr = 2; d1_be = 2'b11; d1_wd = 16'hBEEF;
        tick();
        d1_wr = 0; d1_rd = 1;
        tick();
        n_checks++; if (d1_rvalid !== 1'b1) $display("FAIL lat1_valid got %b exp 1", d1_rvalid); else n_pass++;
        n_checks++; if (d1_rdata !== 16'hBEEF) $display("FAIL lat1_data got %h exp beef", d1_rdata); else n_pass++;
        idle();
        tick();
        n_checks++; if (d1_rvalid !== 1'b0) $display("FAIL lat1_pulse got %b exp 0", d1_rvalid); else n_pass++;
        n_checks++; if (d1_rdata !== 16'hBEEF) $display("FAIL lat1_hold got %h exp beef", d1_rdata); else n_pass++;
        // read and write together: write wins, no valid
        d1_cs = 1; d1_rd = 1; d1_wr = 1; d1_a_addr = 0; d1_be = 2'b11; d1_wd = 16'h1357;
        tick();
        n_checks++; if (d1_rvalid !== 1'b0) $display("FAIL rdwr_novalid got %b exp 0", d1_rvalid); else n_pass++;
        d1_wr = 0;
        tick();
        n_checks++; if (d1_rdata !== 16'h1357) $display("FAIL rdwr_write got %h exp 1357", d1_rdata); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_byteenable();
        idle();
        d1_cs = 1; d1_wr = 1; d1_a_addr = 1; d1_be = 2'b11; d1_wd = 16'h1234; tick();
        d1_be = 2'b10; d1_wd = 16'hABCD; tick();
        d1_wr = 0; d1_rd = 1; tick();
        n_checks++; if (d1_rdata !== 16'hAB34 || d1_rvalid !== 1'b1) $display("FAIL be_upper got %h/%b exp ab34/1", d1_rdata, d1_rvalid); else n_pass++;
        d1_rd = 0; d1_wr = 1; d1_be = 2'b00; d1_wd = 16'hFFFF; tick();
        d1_wr = 0; d1_rd = 1; tick();
        n_checks++; if (d1_rdata !== 16'hAB34 || d1_rvalid !== 1'b1) $display("FAIL be_none got %h/%b exp ab34/1", d1_rdata, d1_rvalid); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_burst_lat2();
        idle();
        d2_cs = 1; d2_rd = 1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin d2_cs = 0; d2_rd = 0; end
            else d2_a_addr = 4'(i);
            tick();
            if (i == 0) begin
                n_checks++; if (d2_rvalid !== 1'b0) $display("FAIL burst_first got %b exp 0", d2_rvalid); else n_pass++;
            end else begin
                n_checks++;
                if (d2_rvalid !== 1'b1 || d2_rdata !== m2[i-1])
                    $display("FAIL burst_%0d got %h/%b exp %h/1", i - 1, d2_rdata, d2_rvalid, m2[i-1]);
                else n_pass++;
            end
        end
        tick();
        n_checks++; if (d2_rvalid !== 1'b0) $display("FAIL burst_end got %b exp 0", d2_rvalid); else n_pass++;
    endtask

    task automatic test_collision();
        idle();
        d1_cs = 1; d1_wr = 1; d1_a_addr = 3; d1_be = 2'b11; d1_wd = 16'h0F0F; tick();
        d1_wd = 16'h5555; d1_b_req = 1; d1_b_addr = 3; tick();
        n_checks++; if (d1_b_rdata !== 16'h0F0F || d1_b_valid !== 1'b1) $display("FAIL coll_old got %h/%b exp 0f0f/1", d1_b_rdata, d1_b_valid); else n_pass++;
        d1_wr = 0; d1_cs = 0; tick();
        n_checks++; if (d1_b_rdata !== 16'h5555 || d1_b_valid !== 1'b1) $display("FAIL coll_new got %h/%b exp 5555/1", d1_b_rdata, d1_b_valid); else n_pass++;
        d1_b_req = 0; tick();
        n_checks++; if (d1_b_valid !== 1'b0) $display("FAIL coll_pulse got %b exp 0", d1_b_valid); else n_pass++;
    endtask

    task automatic test_freeze_stall();
        idle();
        d1_cs = 1; d1_wr = 1; d1_a_addr = 0; d1_be = 2'b11; d1_wd = 16'h2468; tick();
        d1_freeze = 1; d1_wd = 16'hFFFF; tick();
        d1_freeze = 0; d1_wr = 0; d1_rd = 1; tick();
        n_checks++; if (d1_rdata !== 16'h2468) $display("FAIL freeze got %h exp 2468", d1_rdata); else n_pass++;
        d1_cs = 0; d1_rd = 0; d1_clken = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (d1_rvalid !== 1'b1 || d1_rdata !== 16'h2468) $display("FAIL stall1_hold%0d got %h/%b exp 2468/1", i, d1_rdata, d1_rvalid); else n_pass++;
        end
        d1_clken = 1; tick();
        n_checks++; if (d1_rvalid !== 1'b0) $display("FAIL stall1_end got %b exp 0", d1_rvalid); else n_pass++;
        // stall with the read still in the first stage of the LAT2 pipe
        d2_cs = 1; d2_rd = 1; d2_a_addr = 5; tick();
        d2_cs = 0; d2_rd = 0; d2_clken = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (d2_rvalid !== 1'b0) $display("FAIL stall2_wait%0d got %b exp 0", i, d2_rvalid); else n_pass++;
        end
        d2_clken = 1; tick();
        n_checks++; if (d2_rvalid !== 1'b1 || d2_rdata !== m2[5]) $display("FAIL stall2_resume got %h/%b exp %h/1", d2_rdata, d2_rvalid, m2[5]); else n_pass++;
        tick();
        n_checks++; if (d2_rvalid !== 1'b0) $display("FAIL stall2_end got %b exp 0", d2_rvalid); else n_pass++;
    endtask

    task automatic test_async_reset();
        idle();
        d2_cs = 1; d2_wr = 1; d2_a_addr = 7; d2_be = 4'hF; d2_wd = 32'hCAFEF00D; tick();
        d2_wr = 0; d2_rd = 1; tick();
        idle();
        #2 reset_n = 0;
        #1;
        model_reset();
        n_checks++; if (d2_rvalid !== 1'b0 || d2_rdata !== 32'h0) $display("FAIL arst_d2 got %h/%b exp 0/0", d2_rdata, d2_rvalid); else n_pass++;
        n_checks++; if (d1_rdata !== 16'h0 || d1_b_rdata !== 16'h0) $display("FAIL arst_d1 got %h/%h exp 0/0", d1_rdata, d1_b_rdata); else n_pass++;
        tick();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (d2_rvalid !== 1'b0) $display("FAIL arst_noval%0d got %b exp 0", i, d2_rvalid); else n_pass++;
        end
        d2_cs = 1; d2_rd = 1; d2_a_addr = 7; tick();
        idle(); tick();
        n_checks++; if (d2_rvalid !== 1'b1 || d2_rdata !== 32'hCAFEF00D) $display("FAIL arst_mem got %h/%b exp cafef00d/1", d2_rdata, d2_rvalid); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            d1_clken = ($urandom_range(0, 6) != 0); d1_freeze = ($urandom_range(0, 6) == 0);
            d1_cs = ($urandom_range(0, 3) != 0); d1_rd = 1'($urandom); d1_wr = ($urandom_range(0, 2) == 0);
            d1_a_addr = 2'($urandom); d1_b_addr = 2'($urandom); d1_b_req = 1'($urandom);
            d1_be = 2'($urandom); d1_wd = 16'($urandom);
            d2_clken = ($urandom_range(0, 6) != 0); d2_freeze = ($urandom_range(0, 6) == 0);
            d2_cs = ($urandom_range(0, 3) != 0); d2_rd = 1'($urandom); d2_wr = ($urandom_range(0, 2) == 0);
            d2_a_addr = 4'($urandom); d2_b_addr = 4'($urandom); d2_b_req = 1'($urandom);
            d2_be = 4'($urandom); d2_wd = $urandom;
            tick();
            n_checks++; if (d1_rvalid !== e1_av) $display("FAIL rnd_d1_av c%0d got %b exp %b", c, d1_rvalid, e1_av); else n_pass++;
            n_checks++; if (d1_rdata !== e1_ad) $display("FAIL rnd_d1_ad c%0d got %h exp %h", c, d1_rdata, e1_ad); else n_pass++;
            n_checks++; if (d1_b_valid !== e1_bv) $display("FAIL rnd_d1_bv c%0d got %b exp %b", c, d1_b_valid, e1_bv); else n_pass++;
            n_checks++; if (d1_b_rdata !== e1_bd) $display("FAIL rnd_d1_bd c%0d got %h exp %h", c, d1_b_rdata, e1_bd); else n_pass++;
            n_checks++; if (d2_rvalid !== e2_av) $display("FAIL rnd_d2_av c%0d got %b exp %b", c, d2_rvalid, e2_av); else n_pass++;
            n_checks++; if (d2_rdata !== e2_ad) $display("FAIL rnd_d2_ad c%0d got %h exp %h", c, d2_rdata, e2_ad); else n_pass++;
            n_checks++; if (d2_b_valid !== e2_bv) $display("FAIL rnd_d2_bv c%0d got %b exp %b", c, d2_b_valid, e2_bv); else n_pass++;
            n_checks++; if (d2_b_rdata !== e2_bd) $display("FAIL rnd_d2_bd c%0d got %h exp %h", c, d2_b_rdata, e2_bd); else n_pass++;
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_byteenable();
        test_burst_lat2();
        test_collision();
        test_freeze_stall();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
